// File: rtl/lcd_hd44780_ctrl_if.sv
// rtl/lcd_hd44780_ctrl_if.sv - host-side byte write request bundle for the HD44780 sequencer
interface lcd_hd44780_ctrl_if;
    logic       wr;
    logic       rs_in;
    logic       nib;
    logic [7:0] data_in;
    logic       busy;
    logic       drop;

    modport master (
        output wr,
        output rs_in,
        output nib,
        output data_in,
        input  busy,
        input  drop
    );

    modport slave (
        input  wr,
        input  rs_in,
        input  nib,
        input  data_in,
        output busy,
        output drop
    );
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - 4-bit HD44780 LCD write sequencer with E strobe timing and execution wait
module lcd_hd44780_ctrl #(
    parameter int T_AS       = 2,
    parameter int T_PW       = 8,
    parameter int T_H        = 2,
    parameter int EXEC_SHORT = 1100,
    parameter int EXEC_LONG  = 45000
) (
    input  logic               clk,
    input  logic               rst,
    lcd_hd44780_ctrl_if.slave  host,
    output logic               lcd_e,
    output logic               lcd_rw,
    output logic               lcd_rs,
    output logic [3:0]         lcd_db
);

    // Counter reload values: each phase loads (length - 1) and ends when the counter reads 0.
    localparam logic [15:0] AS_M1    = 16'(T_AS - 1);
    localparam logic [15:0] PW_M1    = 16'(T_PW - 1);
    localparam logic [15:0] H_M1     = 16'(T_H - 1);
    localparam logic [15:0] SHORT_M1 = 16'(EXEC_SHORT - 1);
    localparam logic [15:0] LONG_M1  = 16'(EXEC_LONG - 1);

    typedef enum logic [2:0] {
        IDLE, SET_HI, PUL_HI, HLD_HI, SET_LO, PUL_LO, HLD_LO, WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  lo_q, lo_d;       // low nibble kept until the second half of the byte
    logic        nib_q, nib_d;
    logic        long_q, long_d;   // clear/home needs the long execution wait
    logic        rs_q, rs_d;
    logic [3:0]  db_q, db_d;
    logic        e_q, e_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;
    logic        last;

    assign last      = (cnt_q == 16'd0);
    assign host.busy = busy_q;
    assign host.drop = drop_q;
    assign lcd_e     = e_q;
    assign lcd_rw    = 1'b0;
    assign lcd_rs    = rs_q;
    assign lcd_db    = db_q;

    // State register and registered pin outputs; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            lo_q    <= 4'd0;
            nib_q   <= 1'b0;
            long_q  <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 4'd0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            nib_q   <= nib_d;
            long_q  <= long_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    // Phase sequencing: accept in IDLE, walk the nibble phases, then wait out execution time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        nib_d   = nib_q;
        long_d  = long_q;
        rs_d    = rs_q;
        db_d    = db_q;
        drop_d  = host.wr && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (host.wr) begin
                    lo_d    = host.data_in[3:0];
                    nib_d   = host.nib;
                    long_d  = !host.rs_in && !host.nib &&
                              (host.data_in >= 8'h01) && (host.data_in <= 8'h03);
                    rs_d    = host.rs_in;
                    db_d    = host.data_in[7:4];
                    cnt_d   = AS_M1;
                    state_d = SET_HI;
                end
            end
            SET_HI: begin
                if (last) begin
                    state_d = PUL_HI;
                    cnt_d   = PW_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            PUL_HI: begin
                if (last) begin
                    state_d = HLD_HI;
                    cnt_d   = H_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HLD_HI: begin
                if (last) begin
                    if (nib_q) begin
                        state_d = WAIT;
                        cnt_d   = SHORT_M1;
                    end else begin
                        state_d = SET_LO;
                        cnt_d   = AS_M1;
                        db_d    = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            SET_LO: begin
                if (last) begin
                    state_d = PUL_LO;
                    cnt_d   = PW_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            PUL_LO: begin
                if (last) begin
                    state_d = HLD_LO;
                    cnt_d   = H_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            HLD_LO: begin
                if (last) begin
                    state_d = WAIT;
                    cnt_d   = long_q ? LONG_M1 : SHORT_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            WAIT: begin
                if (last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        e_d    = (state_d == PUL_HI) || (state_d == PUL_LO);
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - directed self-checking bench for lcd_hd44780_ctrl
module tb_lcd_hd44780_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_e;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [3:0] lcd_db;

    lcd_hd44780_ctrl_if hif ();

    lcd_hd44780_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .host   (hif.slave),
        .lcd_e  (lcd_e),
        .lcd_rw (lcd_rw),
        .lcd_rs (lcd_rs),
        .lcd_db (lcd_db)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    int         busy_cnt;
    int         drop_cnt;
    int         npulse;
    int         e_hi_cnt;
    int         first_busy;
    int         rise_cyc [4];
    logic [3:0] pulse_db [4];
    logic       pulse_rs [4];
    logic       e_prev = 1'b0;

    always @(negedge clk) begin
        if (hif.busy) begin
            busy_cnt = busy_cnt + 1;
            if (first_busy < 0) first_busy = cyc;
        end
        if (hif.drop) drop_cnt = drop_cnt + 1;
        if (lcd_e) e_hi_cnt = e_hi_cnt + 1;
        if (lcd_e && !e_prev) begin
            if (npulse < 4) begin
                rise_cyc[npulse] = cyc;
                pulse_db[npulse] = lcd_db;
                pulse_rs[npulse] = lcd_rs;
            end
            npulse = npulse + 1;
        end
        e_prev = lcd_e;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        busy_cnt   = 0;
        drop_cnt   = 0;
        npulse     = 0;
        e_hi_cnt   = 0;
        first_busy = -1;
        for (int i = 0; i < 4; i++) begin
            rise_cyc[i] = -1;
            pulse_db[i] = 4'hx;
            pulse_rs[i] = 1'bx;
        end
    endtask

    task automatic send(input logic r, input logic n, input logic [7:0] d, output int edge_n);
        hif.wr      = 1'b1;
        hif.rs_in   = r;
        hif.nib     = n;
        hif.data_in = d;
        edge_n      = cyc;
        nstep();
        hif.wr = 1'b0;
    endtask

    task automatic wait_idle(output int fall);
        for (int k = 0; k < 50000 && hif.busy; k++) nstep();
        fall = cyc;
        if (hif.busy) chk("idle_timeout", 1, 0);
    endtask

    int n0;
    int fall;

    initial begin
        rst         = 1'b1;
        hif.wr      = 1'b0;
        hif.rs_in   = 1'b0;
        hif.nib     = 1'b0;
        hif.data_in = 8'h00;
        clear_mon();
        repeat (3) nstep();
        rst = 1'b0;

        // reset state
        chk("rst_busy", hif.busy, 0);
        chk("rst_drop", hif.drop, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_rw", lcd_rw, 0);
        clear_mon();
        repeat (50) nstep();
        chk("idle_busy_cnt", busy_cnt, 0);
        chk("idle_pulses", npulse, 0);
        chk("idle_db", lcd_db, 0);

        // data byte 0x41
        clear_mon();
        send(1'b1, 1'b0, 8'h41, n0);
        wait_idle(fall);
        chk("d41_first_busy", first_busy, n0 + 1);
        chk("d41_rise0", rise_cyc[0], n0 + 3);
        chk("d41_rise1", rise_cyc[1], n0 + 15);
        chk("d41_db_hi", pulse_db[0], 4'h4);
        chk("d41_db_lo", pulse_db[1], 4'h1);
        chk("d41_rs", pulse_rs[0], 1);
        chk("d41_pulses", npulse, 2);
        chk("d41_e_width", e_hi_cnt, 16);
        chk("d41_fall", fall, n0 + 1125);
        chk("d41_busy_w", busy_cnt, 1124);
        chk("d41_rw", lcd_rw, 0);

        // clear command, then 0x28 in the first idle cycle
        clear_mon();
        send(1'b0, 1'b0, 8'h01, n0);
        wait_idle(fall);
        chk("c01_busy_w", busy_cnt, 45024);
        chk("c01_pulses", npulse, 2);
        chk("c01_rs", pulse_rs[0], 0);
        chk("c01_db_lo", pulse_db[1], 4'h1);
        clear_mon();
        send(1'b0, 1'b0, 8'h28, n0);
        wait_idle(fall);
        chk("c28_busy_w", busy_cnt, 1124);
        chk("c28_pulses", npulse, 2);
        chk("c28_db_hi", pulse_db[0], 4'h2);
        chk("c28_db_lo", pulse_db[1], 4'h8);
        chk("c28_drop", drop_cnt, 0);

        // nibble init write
        clear_mon();
        send(1'b0, 1'b1, 8'h30, n0);
        wait_idle(fall);
        chk("n30_busy_w", busy_cnt, 1112);
        chk("n30_pulses", npulse, 1);
        chk("n30_db", pulse_db[0], 4'h3);
        chk("n30_e_width", e_hi_cnt, 8);

        // write while busy
        clear_mon();
        send(1'b1, 1'b0, 8'h41, n0);
        repeat (3) nstep();
        hif.wr      = 1'b1;
        hif.data_in = 8'h42;
        nstep();
        hif.wr = 1'b0;
        chk("drop_pulse", hif.drop, 1);
        wait_idle(fall);
        chk("drop_cnt", drop_cnt, 1);
        chk("drop_db_hi", pulse_db[0], 4'h4);
        chk("drop_db_lo", pulse_db[1], 4'h1);
        chk("drop_busy_w", busy_cnt, 1124);

        // reset while E is high
        clear_mon();
        send(1'b1, 1'b0, 8'h41, n0);
        for (int k = 0; k < 50 && !lcd_e; k++) nstep();
        chk("mid_e_seen", lcd_e, 1);
        nstep();
        rst = 1'b1;
        nstep();
        rst = 1'b0;
        chk("mid_e", lcd_e, 0);
        chk("mid_busy", hif.busy, 0);
        chk("mid_db", lcd_db, 0);
        chk("mid_rs", lcd_rs, 0);
        clear_mon();
        repeat (100) nstep();
        chk("mid_no_pulse", npulse, 0);
        chk("mid_no_busy", busy_cnt, 0);
        clear_mon();
        send(1'b1, 1'b0, 8'h41, n0);
        wait_idle(fall);
        chk("post_busy_w", busy_cnt, 1124);
        chk("post_db_hi", pulse_db[0], 4'h4);
        chk("post_db_lo", pulse_db[1], 4'h1);

        // wr coincident with rst while busy
        send(1'b0, 1'b0, 8'h28, n0);
        repeat (4) nstep();
        clear_mon();
        rst         = 1'b1;
        hif.wr      = 1'b1;
        hif.data_in = 8'h01;
        nstep();
        rst    = 1'b0;
        hif.wr = 1'b0;
        chk("rw_busy", hif.busy, 0);
        chk("rw_drop", hif.drop, 0);
        repeat (20) nstep();
        chk("rw_drop_cnt", drop_cnt, 0);
        chk("rw_busy_cnt", busy_cnt, 0);
        chk("rw_pulses", npulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
